// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction-supply front end for the SISC core.
// Holds the PC, a preloadable synchronous instruction memory and the
// instruction register, presented to the core with a valid/ack handshake.
module sisc_fetch #(
   parameter int unsigned AW      = 8,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          im_we,
   input  logic [AW-1:0] im_waddr,
   input  logic [31:0]   im_wdata,
   input  logic          ir_ack,
   input  logic          br_take,
   input  logic [AW-1:0] br_addr,
   output logic [31:0]   ir,
   output logic          ir_valid,
   output logic [AW-1:0] pc,
   output logic          halted
);

   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      LOAD    = 2'd1,
      PRESENT = 2'd2,
      HALT    = 2'd3
   } state_t;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   mem_q;
   logic [31:0]   ir_q;
   logic          ir_valid_q;
   logic          halted_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;
   state_t        state_q;

   // Preload/patch port; writes are accepted in every state, even in reset.
   always_ff @(posedge clk) begin
      if (im_we) begin
         mem[im_waddr] <= im_wdata;
      end
   end

   // Next PC: advance after a load, redirect only on an acknowledged branch.
   always_comb begin
      pc_d = pc_q;
      case (state_q)
         LOAD:    pc_d = pc_q + AW'(1);
         PRESENT: if (ir_ack && br_take) pc_d = br_addr;
         default: pc_d = pc_q;
      endcase
   end

   // Fetch sequencer; the memory read sees pre-write data on a same-edge write.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_q    <= FETCH;
         pc_q       <= '0;
         ir_q       <= 32'h0000_0000;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            FETCH: begin
               mem_q      <= mem[pc_q];
               ir_valid_q <= 1'b0;
               state_q    <= LOAD;
            end
            LOAD: begin
               ir_q       <= mem_q;
               ir_valid_q <= 1'b1;
               if (mem_q[31:28] == HALT_OP) begin
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else begin
                  state_q  <= PRESENT;
               end
            end
            PRESENT: begin
               if (ir_ack) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= FETCH;
               end
            end
            default: begin
               state_q <= HALT;
            end
         endcase
      end
   end

   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign pc       = pc_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed self-checking bench for sisc_fetch (AW=8 main instance, AW=4 wrap instance).
module tb_sisc_fetch;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   logic        im_we = 1'b0;
   logic [7:0]  im_waddr = '0;
   logic [31:0] im_wdata = '0;
   logic        ir_ack = 1'b0;
   logic        br_take = 1'b0;
   logic [7:0]  br_addr = '0;
   logic [31:0] ir;
   logic        ir_valid;
   logic [7:0]  pc;
   logic        halted;

   logic        rst4_f = 1'b0;
   logic        we4 = 1'b0;
   logic [3:0]  waddr4 = '0;
   logic [31:0] wdata4 = '0;
   logic        ack4 = 1'b0;
   logic        br4 = 1'b0;
   logic [3:0]  baddr4 = '0;
   logic [31:0] ir4;
   logic        valid4;
   logic [3:0]  pc4;
   logic        halted4;

   int checks = 0;
   int errors = 0;

   sisc_fetch #(.AW(8), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst_f(rst_f), .im_we(im_we), .im_waddr(im_waddr),
      .im_wdata(im_wdata), .ir_ack(ir_ack), .br_take(br_take),
      .br_addr(br_addr), .ir(ir), .ir_valid(ir_valid), .pc(pc),
      .halted(halted)
   );

   sisc_fetch #(.AW(4), .HALT_OP(4'hF)) dut4 (
      .clk(clk), .rst_f(rst4_f), .im_we(we4), .im_waddr(waddr4),
      .im_wdata(wdata4), .ir_ack(ack4), .br_take(br4),
      .br_addr(baddr4), .ir(ir4), .ir_valid(valid4), .pc(pc4),
      .halted(halted4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      im_we = 1'b1; im_waddr = a; im_wdata = d;
      tick();
      im_we = 1'b0;
   endtask

   task automatic go_reset();
      rst_f = 1'b0; ir_ack = 1'b0; br_take = 1'b0;
      tick(); tick();
   endtask

   // Release reset and wait until the first instruction is presented.
   task automatic release_start();
      rst_f = 1'b1;
      tick(); tick();
   endtask

   // Acknowledge the presented word and wait for the next one.
   task automatic ack_next(input logic br, input logic [7:0] a);
      ir_ack = 1'b1; br_take = br; br_addr = a;
      tick();
      ir_ack = 1'b0; br_take = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      go_reset();
      wr(8'd0, 32'h2110_0001);
      wr(8'd1, 32'h1121_1000);
      wr(8'd2, 32'hF000_0000);
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h0, 1'b0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got ir=%h v=%b pc=%h h=%b expected 00000000 0 00 0",
                  ir, ir_valid, pc, halted);
      end
   endtask

   task automatic test_basic();
      rst_f = 1'b1;
      tick();
      checks++;
      if (ir_valid !== 1'b0) begin
         errors++; $display("FAIL first_edge_valid got %b expected 0", ir_valid);
      end
      tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h2110_0001, 1'b1, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL first_load got ir=%h v=%b pc=%h h=%b expected 21100001 1 01 0",
                  ir, ir_valid, pc, halted);
      end
      ir_ack = 1'b1;
      tick();
      checks++;
      if (ir_valid !== 1'b0) begin
         errors++; $display("FAIL ack_drops_valid got %b expected 0", ir_valid);
      end
      tick();
      checks++;
      if (ir_valid !== 1'b0) begin
         errors++; $display("FAIL load_cycle_valid got %b expected 0", ir_valid);
      end
      tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h1121_1000, 1'b1, 8'd2, 1'b0}) begin
         errors++;
         $display("FAIL second_instr got ir=%h v=%b pc=%h h=%b expected 11211000 1 02 0",
                  ir, ir_valid, pc, halted);
      end
      tick(); tick(); tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'hF000_0000, 1'b1, 8'd3, 1'b1}) begin
         errors++;
         $display("FAIL halt_load got ir=%h v=%b pc=%h h=%b expected f0000000 1 03 1",
                  ir, ir_valid, pc, halted);
      end
      tick(); tick(); tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'hF000_0000, 1'b1, 8'd3, 1'b1}) begin
         errors++;
         $display("FAIL halt_frozen got ir=%h v=%b pc=%h h=%b expected f0000000 1 03 1",
                  ir, ir_valid, pc, halted);
      end
      ir_ack = 1'b0;
   endtask

   task automatic test_stall();
      go_reset();
      release_start();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({ir, ir_valid, pc} !== {32'h2110_0001, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL stall_hold[%0d] got ir=%h v=%b pc=%h expected 21100001 1 01",
                     i, ir, ir_valid, pc);
         end
         tick();
      end
      ack_next(1'b0, 8'd0);
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h1121_1000, 1'b1, 8'd2, 1'b0}) begin
         errors++;
         $display("FAIL stall_release got ir=%h v=%b pc=%h h=%b expected 11211000 1 02 0",
                  ir, ir_valid, pc, halted);
      end
   endtask

   task automatic test_branch();
      go_reset();
      wr(8'd5, 32'h1221_1000);
      release_start();
      br_take = 1'b1; br_addr = 8'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({ir, ir_valid, pc} !== {32'h2110_0001, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL br_no_ack[%0d] got ir=%h v=%b pc=%h expected 21100001 1 01",
                     i, ir, ir_valid, pc);
         end
      end
      br_take = 1'b0;
      ack_next(1'b1, 8'd5);
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h1221_1000, 1'b1, 8'd6, 1'b0}) begin
         errors++;
         $display("FAIL branch_target got ir=%h v=%b pc=%h h=%b expected 12211000 1 06 0",
                  ir, ir_valid, pc, halted);
      end
   endtask

   task automatic test_wrap();
      rst4_f = 1'b0;
      we4 = 1'b1; waddr4 = 4'd15; wdata4 = 32'h1B32_2000;
      tick();
      waddr4 = 4'd0; wdata4 = 32'h2110_0001;
      tick();
      we4 = 1'b0;
      rst4_f = 1'b1;
      tick(); tick();
      checks++;
      if ({ir4, valid4, pc4, halted4} !== {32'h2110_0001, 1'b1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL wrap_start got ir=%h v=%b pc=%h h=%b expected 21100001 1 1 0",
                  ir4, valid4, pc4, halted4);
      end
      ack4 = 1'b1; br4 = 1'b1; baddr4 = 4'd15;
      tick();
      ack4 = 1'b0; br4 = 1'b0;
      tick(); tick();
      checks++;
      if ({ir4, valid4, pc4, halted4} !== {32'h1B32_2000, 1'b1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL wrap_top got ir=%h v=%b pc=%h h=%b expected 1b322000 1 0 0",
                  ir4, valid4, pc4, halted4);
      end
      ack4 = 1'b1;
      tick();
      ack4 = 1'b0;
      tick(); tick();
      checks++;
      if ({ir4, valid4, pc4, halted4} !== {32'h2110_0001, 1'b1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL wrap_zero got ir=%h v=%b pc=%h h=%b expected 21100001 1 1 0",
                  ir4, valid4, pc4, halted4);
      end
   endtask

   task automatic test_reset_mid();
      go_reset();
      release_start();
      ack_next(1'b0, 8'd0);
      rst_f = 1'b0;
      tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h0, 1'b0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_present got ir=%h v=%b pc=%h h=%b expected 00000000 0 00 0",
                  ir, ir_valid, pc, halted);
      end
      release_start();
      ack_next(1'b0, 8'd0);
      ack_next(1'b0, 8'd0);
      checks++;
      if ({halted, pc} !== {1'b1, 8'd3}) begin
         errors++;
         $display("FAIL reach_halt got h=%b pc=%h expected 1 03", halted, pc);
      end
      rst_f = 1'b0;
      tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h0, 1'b0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_halt got ir=%h v=%b pc=%h h=%b expected 00000000 0 00 0",
                  ir, ir_valid, pc, halted);
      end
      release_start();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h2110_0001, 1'b1, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL restart got ir=%h v=%b pc=%h h=%b expected 21100001 1 01 0",
                  ir, ir_valid, pc, halted);
      end
   endtask

   task automatic test_write_collision();
      go_reset();
      release_start();
      ack_next(1'b0, 8'd0);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;
      im_we = 1'b1; im_waddr = 8'd2; im_wdata = 32'h1723_4000;
      tick();
      im_we = 1'b0;
      tick();
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'hF000_0000, 1'b1, 8'd3, 1'b1}) begin
         errors++;
         $display("FAIL collide_old got ir=%h v=%b pc=%h h=%b expected f0000000 1 03 1",
                  ir, ir_valid, pc, halted);
      end
      go_reset();
      release_start();
      ack_next(1'b1, 8'd2);
      checks++;
      if ({ir, ir_valid, pc, halted} !== {32'h1723_4000, 1'b1, 8'd3, 1'b0}) begin
         errors++;
         $display("FAIL collide_new got ir=%h v=%b pc=%h h=%b expected 17234000 1 03 0",
                  ir, ir_valid, pc, halted);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_branch();
      test_wrap();
      test_reset_mid();
      test_write_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction-supply end of the SISC `ir` interface: holds the program counter, a preloadable synchronous instruction memory and the instruction register.
- Presents each 32-bit instruction to the SISC core with a valid/ack handshake instead of fixed bench timing.
- Supports branch redirect from the core and stops fetching on HALT (opcode 4'hF).
- Sits between bench/loader and `sisc`; its `ir` output drives the core's `ir` input.

Parameters:
- AW, 8, instruction memory address width; depth = 2^AW words, PC width = AW.
- HALT_OP, 4'hF, value of ir[31:28] that halts fetching.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_f  input  1  synchronous active-low reset.
- im_we  input  1  instruction memory write enable (preload/patch port).
- im_waddr  input  AW  instruction memory write address.
- im_wdata  input  32  instruction memory write data.
- ir_ack  input  1  core has consumed the presented instruction.
- br_take  input  1  redirect PC; sampled only with ir_ack.
- br_addr  input  AW  branch target address.
- ir  output  32  instruction register to core.
- ir_valid  output  1  ir holds a fresh instruction.
- pc  output  AW  address of the next instruction to fetch.
- halted  output  1  HALT instruction reached.

Behaviour:
- Reset (rst_f=0 at a rising edge): pc=0, ir=32'h00000000 (NOP), ir_valid=0, halted=0, state=FETCH. Reset overrides every other input in any state, including mid-handshake. Memory contents are not cleared.
- Memory: 2^AW x 32, write-first-free.
  - Synchronous write when im_we=1, accepted in every state including reset.
  - Synchronous read of mem[pc] in FETCH into internal mem_q.
  - Read and write to the same address on the same edge returns the OLD data.
- FSM states: FETCH, LOAD, PRESENT, HALT.
  - FETCH: mem_q <= mem[pc]; ir_valid=0; next state LOAD.
  - LOAD: ir <= mem_q; ir_valid <= 1; pc <= pc+1 (modulo 2^AW, 2^AW-1 wraps to 0). Next state is HALT if mem_q[31:28]==HALT_OP, otherwise PRESENT.
  - PRESENT: ir and ir_valid are held stable until ir_ack=1.
    - On ir_ack: if br_take=1 then pc <= br_addr; next state FETCH, and ir_valid <= 0 at that edge. ir keeps its last value.
    - br_take without ir_ack is ignored. br_addr is don't-care when br_take=0.
  - HALT: halted=1 (set at the LOAD edge together with ir_valid). ir_valid stays 1 presenting the HALT word. ir_ack and br_take are ignored and pc is frozen. Only reset exits.
- Latency:
  - First ir_valid goes high at the 2nd rising edge after rst_f is sampled 1.
  - Minimum instruction period is 3 cycles (FETCH, LOAD, PRESENT with same-cycle ack).
- ir_ack while ir_valid=0 (FETCH/LOAD) is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Preload mem[0]=21100001, mem[1]=11211000, mem[2]=F0000000; release reset; ack in every PRESENT cycle.
   - ir_valid rises 2 edges after release with ir=21100001, pc=1.
   - Next instructions appear 3 cycles apart.
   - On F0000000: halted=1, ir_valid=1, pc=3; further acks leave pc=3.
2. Same program with ir_ack withheld 10 cycles after the first load -> ir=21100001 and ir_valid=1 stable throughout, pc=1; one ack -> ir=11211000 three cycles later.
3. Preload mem[5]=12211000; at PRESENT of address 0 assert ir_ack=1, br_take=1, br_addr=5 -> next ir=12211000, pc=6.
   - Also check br_take=1 with ir_ack=0 for 3 cycles: no pc change.
4. AW=4, mem[15]=1B322000, mem[0]=21100001; branch to 15 -> ir=1B322000, pc=0; next ack -> ir=21100001, pc=1.
5. Assert rst_f=0 during PRESENT of address 1 -> at that edge ir=00000000, ir_valid=0, pc=0, halted=0. Repeat from HALT state: halted clears. After release, fetch restarts at mem[0].
6. During FETCH of address 2, write im_waddr=2, im_wdata=17234000 on the same edge -> loaded ir is the old mem[2]. After branch back to 2, ir=17234000.
